// File: rtl/fc_pkg.sv
// Shared types and saturation helpers for the FC array result path.
package fc_pkg;

  localparam int unsigned ROWS = 6;

  typedef logic signed [31:0] acc_t;
  typedef logic signed [7:0]  q8_t;

  typedef enum logic {
    ACC_IDLE,
    ACC_ACCUM
  } acc_state_t;

  // Clamp a 33-bit signed intermediate to the 32-bit signed range.
  function automatic acc_t sat32(input logic signed [32:0] v);
    if (v[32] != v[31]) return v[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    return v[31:0];
  endfunction

  function automatic q8_t sat8(input logic signed [32:0] v);
    if (v > 33'sd127)  return 8'sh7F;
    if (v < -33'sd128) return 8'sh80;
    return v[7:0];
  endfunction

endpackage

// File: rtl/fc_result_fifo.sv
// Synchronous result FIFO; the head is read from registered storage, never from the write port.
module fc_result_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             drop,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign head_valid = (count != '0);
  assign full       = (count == FULL_COUNT);
  assign do_pop     = pop & head_valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push    = push & (~full | do_pop);
  assign drop       = push & ~do_push;
  assign head_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fc_result_collector.sv
// Collects systolic FC array outputs per neuron: accumulate tiles, add bias,
// optional ReLU, requantise to int8, and queue results for the consumer.
module fc_result_collector
  import fc_pkg::*;
#(
  parameter int unsigned ARRAY_LATENCY = 7,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned IDX_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               beat_valid,
  input  logic               beat_last,
  input  logic signed [31:0] beat_bias,
  input  logic signed [31:0] output_mac,
  input  logic [4:0]         cfg_shift,
  input  logic               cfg_relu,
  output logic               res_valid,
  input  logic               res_ready,
  output logic signed [7:0]  res_data,
  output logic signed [31:0] res_acc,
  output logic [IDX_W-1:0]   res_index,
  output logic               overflow
);

  localparam int unsigned ENTRY_W = 8 + 32 + IDX_W;

  logic [ARRAY_LATENCY-1:0] tag_valid;
  logic [ARRAY_LATENCY-1:0] tag_last;
  acc_t                     tag_bias [ARRAY_LATENCY];

  logic d_valid;
  logic d_last;
  acc_t d_bias;

  acc_state_t state, state_next;
  acc_t       acc, acc_next;
  acc_t       finish_sum;
  logic       finish;

  logic             stage_valid;
  acc_t             stage_sum;
  logic [IDX_W-1:0] stage_index;
  logic [IDX_W-1:0] neuron_cnt;

  logic signed [32:0] relu_ext;
  logic signed [32:0] round_add;
  logic signed [32:0] shifted;
  q8_t                quant;

  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head_data;
  logic               drop;

  // Tags travel alongside the beat so each array output is matched to its beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
      tag_last  <= '0;
      for (int unsigned i = 0; i < ARRAY_LATENCY; i++) tag_bias[i] <= '0;
    end else begin
      tag_valid[0] <= beat_valid;
      tag_last[0]  <= beat_valid & beat_last;
      tag_bias[0]  <= (beat_valid && beat_last) ? beat_bias : '0;
      for (int unsigned i = 1; i < ARRAY_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_last[i]  <= tag_last[i-1];
        tag_bias[i]  <= tag_bias[i-1];
      end
    end
  end

  assign d_valid = tag_valid[ARRAY_LATENCY-1];
  assign d_last  = tag_last[ARRAY_LATENCY-1];
  assign d_bias  = tag_bias[ARRAY_LATENCY-1];

  always_comb begin
    state_next = state;
    acc_next   = acc;
    finish     = 1'b0;
    if (d_valid) begin
      if (state == ACC_IDLE) acc_next = output_mac;
      else                   acc_next = sat32({acc[31], acc} + {output_mac[31], output_mac});
      finish     = d_last;
      state_next = d_last ? ACC_IDLE : ACC_ACCUM;
    end
    finish_sum = sat32({acc_next[31], acc_next} + {d_bias[31], d_bias});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACC_IDLE;
      acc         <= '0;
      stage_valid <= 1'b0;
      stage_sum   <= '0;
      stage_index <= '0;
      neuron_cnt  <= '0;
    end else begin
      state       <= state_next;
      acc         <= acc_next;
      stage_valid <= finish;
      if (finish) begin
        stage_sum   <= finish_sum;
        stage_index <= neuron_cnt;
        neuron_cnt  <= neuron_cnt + IDX_W'(1);
      end
    end
  end

  // Round half up: add 2^(shift-1) before the arithmetic shift, in 33 bits so it cannot wrap.
  always_comb begin
    relu_ext  = (cfg_relu && stage_sum < 0) ? '0 : {stage_sum[31], stage_sum};
    round_add = (cfg_shift != 5'd0) ? (33'sd1 <<< (cfg_shift - 5'd1)) : '0;
    shifted   = (relu_ext + round_add) >>> cfg_shift;
    quant     = sat8(shifted);
  end

  assign push_data = {quant, stage_sum, stage_index};

  fc_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (stage_valid),
    .push_data  (push_data),
    .drop       (drop),
    .pop        (res_ready),
    .head_valid (res_valid),
    .head_data  (head_data)
  );

  assign res_data  = head_data[ENTRY_W-1 -: 8];
  assign res_acc   = head_data[IDX_W +: 32];
  assign res_index = head_data[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst)       overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_fc_result_collector.sv
// Directed bench for fc_result_collector: vector table plus multi-cycle corner sequences.
module tb_fc_result_collector;

  localparam int LAT   = 7;
  localparam int DEPTH = 4;
  localparam int IW    = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               beat_valid;
  logic               beat_last;
  logic signed [31:0] beat_bias;
  logic signed [31:0] output_mac;
  logic [4:0]         cfg_shift;
  logic               cfg_relu;
  logic               res_valid;
  logic               res_ready;
  logic signed [7:0]  res_data;
  logic signed [31:0] res_acc;
  logic [IW-1:0]      res_index;
  logic               overflow;

  int checks   = 0;
  int failures = 0;

  logic signed [31:0] mac_dly [LAT];

  typedef struct {
    logic               relu;
    logic [4:0]         shift;
    logic signed [31:0] mac;
    logic signed [31:0] bias;
    logic signed [7:0]  exp_data;
    logic signed [31:0] exp_acc;
  } vec_t;

  vec_t vecs [12];

  fc_result_collector #(
    .ARRAY_LATENCY (LAT),
    .FIFO_DEPTH    (DEPTH),
    .IDX_W         (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .beat_valid (beat_valid),
    .beat_last  (beat_last),
    .beat_bias  (beat_bias),
    .output_mac (output_mac),
    .cfg_shift  (cfg_shift),
    .cfg_relu   (cfg_relu),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_acc    (res_acc),
    .res_index  (res_index),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, $signed(act), $signed(exp));
    end
  endtask

  // One clock cycle: drive this cycle's beat, emulate the array returning sums LAT cycles later.
  task automatic cycle(input logic v, input logic l, input logic signed [31:0] bias,
                       input logic signed [31:0] mac);
    beat_valid = v;
    beat_last  = l;
    beat_bias  = bias;
    output_mac = mac_dly[LAT-1];
    for (int i = LAT - 1; i > 0; i--) mac_dly[i] = mac_dly[i-1];
    mac_dly[0] = v ? mac : 32'sh5A5A_5A5A;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 32'sd0, 32'sd0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    res_ready = 1'b0;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic expect_head(input string name, input logic signed [7:0] d,
                             input logic signed [31:0] a, input logic [IW-1:0] idx);
    check({name, "_valid"}, res_valid, 1'b1);
    check({name, "_data"},  res_data,  d);
    check({name, "_acc"},   res_acc,   a);
    check({name, "_index"}, res_index, idx);
  endtask

  task automatic pop();
    res_ready = 1'b1;
    idle(1);
    res_ready = 1'b0;
  endtask

  task automatic expect_reset_state(input string name);
    check({name, "_valid"},    res_valid, 1'b0);
    check({name, "_data"},     res_data,  8'sd0);
    check({name, "_acc"},      res_acc,   32'sd0);
    check({name, "_index"},    res_index, 16'd0);
    check({name, "_overflow"}, overflow,  1'b0);
  endtask

  logic signed [7:0]  relu_exp [2][3];
  logic signed [31:0] relu_sum [3];

  initial begin
    vecs[0]  = '{1'b0, 5'd0,  -32'sd50,        32'sd0,    -8'sd50, -32'sd50};
    vecs[1]  = '{1'b1, 5'd0,  -32'sd50,        32'sd0,    8'sd0,   -32'sd50};
    vecs[2]  = '{1'b0, 5'd4,  32'sd2000,       32'sd48,   8'sd127, 32'sd2048};
    vecs[3]  = '{1'b0, 5'd3,  32'sd20,         32'sd0,    8'sd3,   32'sd20};
    vecs[4]  = '{1'b0, 5'd3,  -32'sd20,        32'sd0,    -8'sd2,  -32'sd20};
    vecs[5]  = '{1'b0, 5'd1,  -32'sd3,         32'sd0,    -8'sd1,  -32'sd3};
    vecs[6]  = '{1'b1, 5'd2,  -32'sd7,         32'sd10,   8'sd1,   32'sd3};
    vecs[7]  = '{1'b0, 5'd31, 32'sh7FFF_FFF0,  32'sh100,  8'sd1,   32'sh7FFF_FFFF};
    vecs[8]  = '{1'b0, 5'd31, 32'sh8000_0000,  -32'sd1,   -8'sd1,  32'sh8000_0000};
    vecs[9]  = '{1'b0, 5'd0,  -32'sd1000,      32'sd0,    8'sh80,  -32'sd1000};
    vecs[10] = '{1'b0, 5'd1,  32'sd254,        32'sd0,    8'sd127, 32'sd254};
    vecs[11] = '{1'b0, 5'd1,  -32'sd256,       32'sd0,    8'sh80,  -32'sd256};

    relu_sum[0] = -32'sd50; relu_sum[1] = 32'sd1000; relu_sum[2] = -32'sd1000;
    relu_exp[0][0] = -8'sd50; relu_exp[0][1] = 8'sd127; relu_exp[0][2] = 8'sh80;
    relu_exp[1][0] = 8'sd0;   relu_exp[1][1] = 8'sd127; relu_exp[1][2] = 8'sd0;

    for (int i = 0; i < LAT; i++) mac_dly[i] = '0;
    beat_valid = 1'b0; beat_last = 1'b0; beat_bias = '0; output_mac = '0;
    cfg_shift = 5'd0; cfg_relu = 1'b0;

    do_reset();
    expect_reset_state("reset");

    // Three-tile neuron: last beat at cycle 2, result must appear at cycle 11.
    cfg_shift = 5'd2;
    cycle(1'b1, 1'b0, 32'sd0,  32'sd100);
    cycle(1'b1, 1'b0, 32'sd0,  -32'sd20);
    cycle(1'b1, 1'b1, 32'sd10, 32'sd5);
    idle(7);
    check("three_tile_early_valid", res_valid, 1'b0);
    idle(1);
    expect_head("three_tile", 8'sd24, 32'sd95, 16'd0);
    pop();
    check("three_tile_popped", res_valid, 1'b0);

    // ReLU off then on, three single-tile neurons back-to-back each.
    for (int r = 0; r < 2; r++) begin
      do_reset();
      cfg_shift = 5'd0;
      cfg_relu  = (r == 1);
      for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 32'sd0, relu_sum[k]);
      idle(LAT + 1);
      for (int k = 0; k < 3; k++) begin
        expect_head($sformatf("relu%0d_n%0d", r, k), relu_exp[r][k], relu_sum[k], IW'(k));
        pop();
      end
      check($sformatf("relu%0d_drained", r), res_valid, 1'b0);
    end

    // Vector table of isolated single-tile neurons.
    do_reset();
    foreach (vecs[i]) begin
      cfg_relu  = vecs[i].relu;
      cfg_shift = vecs[i].shift;
      cycle(1'b1, 1'b1, vecs[i].bias, vecs[i].mac);
      idle(LAT + 1);
      expect_head($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_acc, IW'(i));
      pop();
    end
    check("vec_drained", res_valid, 1'b0);

    // Accumulator saturation across two tiles.
    do_reset();
    cfg_relu = 1'b0; cfg_shift = 5'd0;
    cycle(1'b1, 1'b0, 32'sd0, 32'sh7FFF_FFF0);
    cycle(1'b1, 1'b1, 32'sd0, 32'sh100);
    idle(LAT + 1);
    expect_head("acc_sat", 8'sd127, 32'sh7FFF_FFFF, 16'd0);
    pop();

    // Back-pressure: five neurons into a four-entry FIFO, the fifth is dropped.
    do_reset();
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 32'sd0, 32'(k * 10 + 1));
    idle(LAT + 2);
    check("bp_overflow", overflow, 1'b1);
    expect_head("bp_hold0", 8'sd1, 32'sd1, 16'd0);
    idle(1);
    expect_head("bp_hold1", 8'sd1, 32'sd1, 16'd0);
    for (int k = 0; k < 4; k++) begin
      expect_head($sformatf("bp_n%0d", k), 8'(k * 10 + 1), 32'(k * 10 + 1), IW'(k));
      pop();
    end
    check("bp_drained", res_valid, 1'b0);
    check("bp_overflow_sticky", overflow, 1'b1);

    // Reset after two of three beats discards the partial neuron.
    cycle(1'b1, 1'b0, 32'sd0, 32'sd111);
    cycle(1'b1, 1'b0, 32'sd0, 32'sd222);
    do_reset();
    expect_reset_state("midrst");
    idle(LAT + 3);
    check("midrst_no_ghost", res_valid, 1'b0);
    cfg_shift = 5'd1;
    cycle(1'b1, 1'b1, 32'sd0, 32'sd8);
    idle(LAT + 1);
    expect_head("midrst_new", 8'sd4, 32'sd8, 16'd0);
    pop();

    // Full FIFO with push and pop landing in the same cycle.
    do_reset();
    cfg_shift = 5'd0;
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 32'sd0, 32'(k + 1));
    idle(LAT + 3);
    expect_head("full_pre", 8'sd1, 32'sd1, 16'd0);
    cycle(1'b1, 1'b1, 32'sd0, 32'sd5);
    idle(LAT);
    pop();
    check("full_pushpop_overflow", overflow, 1'b0);
    for (int k = 1; k < 5; k++) begin
      expect_head($sformatf("full_n%0d", k), 8'(k + 1), 32'(k + 1), IW'(k));
      pop();
    end
    check("full_drained", res_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
